// File: rtl/preprocess_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 16x16 signed multiplier, with a credit-reserved result FIFO.
// Define PREPROCESS_MUL_ARB_Q15_EN to store rounded/saturated Q15 results (adds one pipeline stage).
module preprocess_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_a,
  input  logic [NUM_REQ*16-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_p
);

`ifdef PREPROCESS_MUL_ARB_Q15_EN
  localparam int PIPE = LATENCY + 1;
`else
  localparam int PIPE = LATENCY;
`endif
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + PIPE + 1) + 1;

  function automatic logic [31:0] mul16(input logic [31:0] ab);
    logic signed [31:0] prod;
    prod = $signed(ab[31:16]) * $signed(ab[15:0]);
    return prod;
  endfunction

`ifdef PREPROCESS_MUL_ARB_Q15_EN
  function automatic logic [31:0] q15(input logic [31:0] p);
    logic signed [32:0] t;
    logic signed [17:0] s;
    t = $signed({p[31], p}) + 33'sd16384;
    s = t[32:15];
    if (s > 18'sd32767) begin
      q15 = 32'h0000_7FFF;
    end else if (s < -18'sd32768) begin
      q15 = 32'hFFFF_8000;
    end else begin
      q15 = {{16{s[15]}}, s[15:0]};
    end
  endfunction
`endif

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] win_s;
  logic            found_s;
  logic            credit_ok_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            head_from_push_s;
  logic [CW-1:0]   in_flight_r;
  logic [CW-1:0]   occ_r;
  logic [CW-1:0]   occ_nxt_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   rd_nxt_s;
  logic [31:0]     wdata_s;
  logic [ID_W-1:0] wid_s;

  // Stage 0 holds the packed operands {a,b}; later stages hold the product.
  logic [PIPE-1:0] stg_v_r;
  logic [ID_W-1:0] stg_id_r [PIPE];
  logic [31:0]     stg_d_r  [PIPE];
  logic [31:0]     mem_p_r  [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id_r [FIFO_DEPTH];

  // Round-robin scan starting just after the last winner
  always_comb begin
    found_s = 1'b0;
    win_s   = {ID_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found_s && req_valid[(int'(rr_ptr_r) + i) % NUM_REQ]) begin
        found_s = 1'b1;
        win_s   = ID_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign credit_ok_s = (in_flight_r + occ_r) < CW'(FIFO_DEPTH);
  assign issue_s     = found_s && credit_ok_s && !ap_rst;
  assign push_s      = stg_v_r[PIPE-1];
  assign pop_s       = rsp_valid && rsp_ready;

  // Grant decode: only the winner sees ready, and only with a free credit
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (issue_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // FIFO write data from the last pipeline stage
  always_comb begin
`ifdef PREPROCESS_MUL_ARB_Q15_EN
    wdata_s = q15(stg_d_r[PIPE-1]);
`else
    if (PIPE == 1) begin
      wdata_s = mul16(stg_d_r[0]);
    end else begin
      wdata_s = stg_d_r[PIPE-1];
    end
`endif
    wid_s = stg_id_r[PIPE-1];
  end

  // Occupancy and read-pointer look-ahead used to register the head entry
  always_comb begin
    rd_nxt_s = pop_s ? wrap_inc(rd_ptr_r) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + CW'(1);
      2'b01:   occ_nxt_s = occ_r - CW'(1);
      default: occ_nxt_s = occ_r;
    endcase
    head_from_push_s = push_s && ((occ_r == CW'(0)) || ((occ_r == CW'(1)) && pop_s));
  end

  // Multiplier pipeline shift register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stg_v_r <= {PIPE{1'b0}};
      for (int k = 0; k < PIPE; k++) begin
        stg_id_r[k] <= {ID_W{1'b0}};
        stg_d_r[k]  <= 32'h0;
      end
    end else begin
      stg_v_r[0] <= issue_s;
      if (issue_s) begin
        stg_id_r[0] <= win_s;
        stg_d_r[0]  <= {req_a[16*int'(win_s) +: 16], req_b[16*int'(win_s) +: 16]};
      end
      for (int k = 1; k < PIPE; k++) begin
        stg_v_r[k]  <= stg_v_r[k-1];
        stg_id_r[k] <= stg_id_r[k-1];
        stg_d_r[k]  <= (k == 1) ? mul16(stg_d_r[0]) : stg_d_r[k-1];
      end
    end
  end

  // Credits, FIFO storage, arbitration pointer and registered head outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      in_flight_r <= {CW{1'b0}};
      occ_r       <= {CW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      rr_ptr_r    <= ID_W'(NUM_REQ - 1);
      rsp_valid   <= 1'b0;
      rsp_id      <= {ID_W{1'b0}};
      rsp_p       <= 32'h0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_p_r[k]  <= 32'h0;
        mem_id_r[k] <= {ID_W{1'b0}};
      end
    end else begin
      case ({issue_s, push_s})
        2'b10:   in_flight_r <= in_flight_r + CW'(1);
        2'b01:   in_flight_r <= in_flight_r - CW'(1);
        default: in_flight_r <= in_flight_r;
      endcase
      occ_r    <= occ_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      if (push_s) begin
        mem_p_r[wr_ptr_r]  <= wdata_s;
        mem_id_r[wr_ptr_r] <= wid_s;
        wr_ptr_r           <= wrap_inc(wr_ptr_r);
      end
      if (issue_s) begin
        rr_ptr_r <= win_s;
      end
      rsp_valid <= (occ_nxt_s != CW'(0));
      if (head_from_push_s) begin
        rsp_id <= wid_s;
        rsp_p  <= wdata_s;
      end else if (occ_nxt_s != CW'(0)) begin
        rsp_id <= mem_id_r[rd_nxt_s];
        rsp_p  <= mem_p_r[rd_nxt_s];
      end
    end
  end

endmodule

// File: tb/tb_preprocess_mul_arbiter.sv
// Directed bench for preprocess_mul_arbiter: per-cycle grant model plus an in-order response scoreboard.
module tb_preprocess_mul_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 2;
`ifdef PREPROCESS_MUL_ARB_Q15_EN
  localparam int LAT = LATENCY + 1;
`else
  localparam int LAT = LATENCY;
`endif

  logic                  ap_clk    = 1'b0;
  logic                  ap_rst    = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a     = '0;
  logic [NUM_REQ*16-1:0] req_b     = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_p;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     p;
    int              ic;
  } ent_t;

  ent_t sb[$];
  int   grants[$];
  int   cyc = 0, checks = 0, passes = 0, fails = 0, model_rr = NUM_REQ - 1, issues = 0;
  int   base;

  preprocess_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_p(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
`ifdef PREPROCESS_MUL_ARB_Q15_EN
    begin
      longint r;
      r = (longint'(p) + 64'sd16384) >>> 15;
      if (r > 64'sd32767) r = 64'sd32767;
      else if (r < -64'sd32768) r = -64'sd32768;
      return 32'(r);
    end
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge check ready/response against the model, then advance.
  task automatic tick();
    int win;
    logic [NUM_REQ-1:0] exp_rdy;
    logic exp_vld;
    ent_t e;
    @(negedge ap_clk);
    if (!ap_rst) begin
      win = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        int j;
        j = (model_rr + i) % NUM_REQ;
        if (win < 0 && req_valid[j]) win = j;
      end
      exp_rdy = (win >= 0 && sb.size() < FIFO_DEPTH) ? NUM_REQ'(1 << win) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      exp_vld = (sb.size() > 0) && (cyc >= sb[0].ic + LAT + 1);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
      if (exp_vld && rsp_ready) begin
        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        chk("rsp_p", 64'(rsp_p), 64'(sb[0].p));
        void'(sb.pop_front());
      end
      if (exp_rdy != '0) begin
        e.id = ID_W'(win);
        e.p  = model_p(req_a[16*win +: 16], req_b[16*win +: 16]);
        e.ic = cyc;
        sb.push_back(e);
        grants.push_back(win);
        model_rr = win;
        issues++;
      end
    end
    @(posedge ap_clk);
    cyc++;
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) tick();
    repeat (2) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset values
    #1 ap_rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_p", 64'(rsp_p), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge ap_clk);
    #2 ap_rst = 1'b0;

    // 1: single request from requester 2, 3 * -4
    req_a[47:32] = 16'd3;
    req_b[47:32] = 16'hFFFC;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("t1_grant", 64'(grants[0]), 64'd2);
    chk("t1_prod", 64'(sb[0].p), 64'(model_p(16'd3, 16'hFFFC)));
    drain();

    // 2: all requesters valid, continuous round robin
    grants.delete();
    req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      rand_ops();
      tick();
    end
    chk("t2_first", 64'(grants[0]), 64'd3);
    for (int i = 1; i < grants.size(); i++)
      chk("t2_order", 64'(grants[i]), 64'((grants[0] + i) % NUM_REQ));
    drain();

    // 3: corner products, each requester dropped once served
    req_a[15:0]  = 16'h8000; req_b[15:0]  = 16'h8000;
    req_a[31:16] = 16'h7FFF; req_b[31:16] = 16'h8000;
    req_a[47:32] = 16'h0000; req_b[47:32] = 16'h1234;
    req_valid = 4'b0111;
    grants.delete();
    for (int n = 0; n < 12 && req_valid != '0; n++) begin
      base = grants.size();
      tick();
      if (grants.size() > base) req_valid[grants[base]] = 1'b0;
    end
    chk("t3_served", 64'(req_valid), 64'd0);
    drain();

    // 4: backpressure -- exactly FIFO_DEPTH issues, then one pop frees one issue
    rsp_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    base = issues;
    repeat (8) tick();
    chk("t4_issues", 64'(issues - base), 64'(FIFO_DEPTH));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (4) tick();
    chk("t4_one_more", 64'(issues - base), 64'(FIFO_DEPTH + 1));
    drain();

    // 5: streaming with random response backpressure
    req_valid = '1;
    for (int n = 0; n < 40; n++) begin
      rand_ops();
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // 6: reset mid-stream with operations in flight
    req_valid = '1;
    rand_ops();
    repeat (4) tick();
    #2 ap_rst = 1'b1;
    #1;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    model_rr = NUM_REQ - 1;
    grants.delete();
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2 ap_rst = 1'b0;
    repeat (3) tick();
    chk("t6_first_grant", 64'(grants[0]), 64'd0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/preprocess_mul_arbiter.md
Name: preprocess_mul_arbiter

Overview:
- Shares one pipelined 16x16 signed multiplier between NUM_REQ preprocessing requesters (window, pre-emphasis, filterbank stages) using round-robin arbitration.
- Each request is a valid/ready operand pair. Results return in issue order on one response channel, tagged with the requester index.
- A credit-controlled result FIFO absorbs response backpressure, so the multiplier pipeline never stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, multiplier pipeline stages from issue to FIFO write (1..4).
- FIFO_DEPTH, 4, result FIFO entries; must be >= LATENCY+1 for one issue per cycle sustained.
- ID_W, 2, requester tag width; ID_W = clog2(NUM_REQ).

Ports:
- ap_clk in 1: clock; all logic on rising edge.
- ap_rst in 1: asynchronous, active-high reset.
- req_valid in NUM_REQ: per-requester operand valid.
- req_ready out NUM_REQ: per-requester accept, one-hot or zero.
- req_a in NUM_REQ*16: signed operand A; requester i uses bits [16i+15:16i].
- req_b in NUM_REQ*16: signed operand B, same packing as req_a.
- rsp_valid out 1: result available at FIFO head.
- rsp_ready in 1: consumer accepts the head entry.
- rsp_id out ID_W: requester index of the head result.
- rsp_p out 32: product of the head result.

Behaviour:
- Reset (async assert):
  - all pipeline valid bits cleared, FIFO emptied, in_flight=0, occupancy=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - rsp_valid=0, rsp_id=0, rsp_p=0, req_ready=0.
  - In-flight operations are discarded with no response. The block is usable on the first edge after deassert.
- Credit check: credit_ok = (in_flight + occupancy) < FIFO_DEPTH. Both counters are registered.
- Arbitration (combinational from registered state):
  - Scan requesters starting at (rr_ptr+1) mod NUM_REQ; the first with req_valid=1 wins.
  - req_ready[win]=credit_ok; all other ready bits are 0.
  - Issue happens when req_valid[win] & req_ready[win].
  - On issue, rr_ptr<=win. With no issue, rr_ptr holds.
- Handshake rules:
  - req_ready never depends on req_a or req_b.
  - A requester may drop valid without being served; no state changes.
- Pipeline:
  - Issue captures a, b and id into stage 1.
  - p = $signed(a)*$signed(b), full 32-bit and exact; -32768*-32768 = 0x40000000.
  - The result is written into the FIFO exactly LATENCY cycles after the issue edge.
  - One issue per cycle maximum.
- in_flight counter:
  - +1 on issue, -1 on FIFO write, unchanged when both occur in the same cycle.
  - Maximum value is LATENCY.
- FIFO:
  - rsp_valid = occupancy != 0. rsp_id and rsp_p show the head entry and are registered (no combinational path from inputs).
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave occupancy unchanged, including when full or empty-with-push (the pushed entry appears at the head the next cycle).
  - Overflow is impossible by construction, because credits reserve space at issue.
  - Read and write pointers wrap mod FIFO_DEPTH.
- Ordering and fairness:
  - Responses leave in issue order.
  - With all requesters valid continuously, each gets exactly one grant every NUM_REQ grants.
- Backpressure: with rsp_ready=0 held, at most FIFO_DEPTH issues occur; after that req_ready stays 0 until a pop.

Optional Feature:
- PREPROCESS_MUL_ARB_Q15_EN defined:
  - Stored result = sat16((p + 0x4000) >>> 15), sign-extended to 32 bits.
  - Round half-up; sat16 clamps to [-32768, 32767].
  - Adds one pipeline stage, so write latency becomes LATENCY+1. The credit limit uses the same FIFO_DEPTH.
- Not defined: raw 32-bit product, latency LATENCY.

Test Plan:
1. Reset then single request: req 2 issues a=3, b=-4 at cycle t -> rsp_valid at t+LATENCY+1 with rsp_id=2, rsp_p=0xFFFFFFF4; req_ready[2]=1 in cycle t.
2. Round robin: all 4 requests valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1; one issue per cycle; no response gaps after fill.
3. Corner products: (-32768,-32768) -> 0x40000000; (32767,-32768) -> 0xC0008000; (0,x) -> 0. With Q15_EN, these give 0x00007FFF (saturated), 0xFFFF8001, and 0.
4. Backpressure: rsp_ready=0 with all requests valid -> exactly 4 issues, then req_ready=0. Raising rsp_ready for 1 cycle -> one pop and one new issue; order and ids preserved.
5. Simultaneous push/pop at full FIFO with rsp_ready=1 -> occupancy stays 4 and no entry is lost or duplicated (check with a scoreboard).
6. ap_rst asserted mid-stream with 2 operations in flight -> rsp_valid=0 immediately and no stale responses after release. The first grant after release goes to requester 0.
